// File: rtl/t05_huffman_decoder.sv
// Bit-serial Huffman decoder: walks the 71-bit tree node format from the root,
// one compressed bit per level, and emits one 8-bit character per leaf reached.
module t05_huffman_decoder #(
    parameter int unsigned NODE_W = 71,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              start,
    input  logic [6:0]        root_index,
    input  logic [CNT_W-1:0]  num_chars,
    output logic              node_req,
    output logic [6:0]        node_addr,
    input  logic              node_valid,
    input  logic [NODE_W-1:0] node_data,
    input  logic              bit_in,
    input  logic              bit_valid,
    output logic              bit_ready,
    output logic [7:0]        char_out,
    output logic              char_valid,
    input  logic              char_ready,
    output logic              busy,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StWaitNode,
        StWaitBit,
        StEmit,
        StDone
    } state_e;

    state_e           r_state, w_state_d;
    logic [6:0]       r_root, w_root_d;
    logic [6:0]       r_cur, w_cur_d;
    logic [CNT_W-1:0] r_rem, w_rem_d;
    logic [8:0]       r_left, w_left_d;
    logic [8:0]       r_right, w_right_d;
    logic [7:0]       r_char, w_char_d;
    logic             r_error, w_error_d;
    logic             r_node_req;
    logic             r_char_valid;
    logic             r_done;
    logic [8:0]       w_child;
    logic             w_unused;

    // max_index and sum fields are not needed to walk the tree
    assign w_unused = ^{node_data[NODE_W-1:64], node_data[45:0]};

    assign w_child = bit_in ? r_right : r_left;

    always_comb begin
        w_state_d = r_state;
        w_root_d  = r_root;
        w_cur_d   = r_cur;
        w_rem_d   = r_rem;
        w_left_d  = r_left;
        w_right_d = r_right;
        w_char_d  = r_char;
        w_error_d = r_error;
        unique case (r_state)
            StIdle, StDone: begin
                if (start) begin
                    w_root_d  = root_index;
                    w_rem_d   = num_chars;
                    w_error_d = 1'b0;
                    if (num_chars == '0) begin
                        w_state_d = StDone;
                    end else begin
                        w_cur_d   = root_index;
                        w_state_d = StFetch;
                    end
                end
            end
            StFetch: begin
                w_state_d = StWaitNode;
            end
            StWaitNode: begin
                if (node_valid) begin
                    w_left_d  = node_data[63:55];
                    w_right_d = node_data[54:46];
                    w_state_d = StWaitBit;
                end
            end
            StWaitBit: begin
                if (bit_valid) begin
                    if (!w_child[8]) begin
                        w_char_d  = w_child[7:0];
                        w_state_d = StEmit;
                    end else if (w_child[7] || (w_child[6:0] > r_root)) begin
                        // child points outside the tree that was loaded
                        w_error_d = 1'b1;
                        w_state_d = StDone;
                    end else begin
                        w_cur_d   = w_child[6:0];
                        w_state_d = StFetch;
                    end
                end
            end
            StEmit: begin
                if (char_ready) begin
                    w_rem_d = r_rem - 1'b1;
                    if (r_rem == CNT_W'(1)) begin
                        w_state_d = StDone;
                    end else begin
                        w_cur_d   = r_root;
                        w_state_d = StFetch;
                    end
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state      <= StIdle;
            r_root       <= '0;
            r_cur        <= '0;
            r_rem        <= '0;
            r_left       <= '0;
            r_right      <= '0;
            r_char       <= '0;
            r_error      <= 1'b0;
            r_node_req   <= 1'b0;
            r_char_valid <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_root       <= w_root_d;
            r_cur        <= w_cur_d;
            r_rem        <= w_rem_d;
            r_left       <= w_left_d;
            r_right      <= w_right_d;
            r_char       <= w_char_d;
            r_error      <= w_error_d;
            r_node_req   <= (w_state_d == StFetch);
            r_char_valid <= (w_state_d == StEmit);
            r_done       <= (w_state_d == StDone);
        end
    end

    assign node_req   = r_node_req;
    assign node_addr  = r_cur;
    assign char_out   = r_char;
    assign char_valid = r_char_valid;
    assign done       = r_done;
    assign error      = r_error;
    assign bit_ready  = (r_state == StWaitBit);
    assign busy       = (r_state != StIdle) && (r_state != StDone);

endmodule
